// File: rtl/msu_sample_fifo.sv
// rtl/msu_sample_fifo.sv - single-clock show-ahead PCM frame FIFO for the MSU-1 audio path
// Block RAM with registered read feeding one output register; occupancy counts the whole prefetch path.
module msu_sample_fifo #(
    parameter int DW        = 16,
    parameter int CH        = 2,
    parameter int AW        = 10,
    parameter int AF_LEVEL  = 768,
    parameter int HOLD_LAST = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_req,
    input  logic             wr_mono,
    input  logic [CH*DW-1:0] wr_data,
    output logic             full,
    output logic             afull,
    input  logic             rd_req,
    output logic [CH*DW-1:0] rd_data,
    output logic             empty,
    output logic [AW:0]      used,
    output logic             ovf,
    output logic             unf
);

    localparam int FW = CH * DW;
    localparam logic [AW:0] DEPTH  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_THR = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    logic [FW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   ram_cnt, ram_cnt_next;
    logic [AW:0]   used_q, used_next;
    logic [FW-1:0] ram_q, out_q, last_q, wr_frame;
    logic          q_valid, out_valid;
    logic          full_q, afull_q, ovf_q, unf_q;
    logic          wr_acc, rd_acc, q_move, ram_rd;

    // Flags come from pre-edge registered state, so FULL+both gives read-only and EMPTY+both write-only.
    always_comb begin
        wr_frame = wr_mono ? {CH{wr_data[DW-1:0]}} : wr_data;
        wr_acc   = wr_req && !full_q;
        rd_acc   = rd_req && out_valid;
        q_move   = q_valid && (!out_valid || rd_acc);
        ram_rd   = (ram_cnt != '0) && (!q_valid || q_move);

        used_next = used_q;
        case ({wr_acc, rd_acc})
            2'b10:   used_next = used_q + ONE;
            2'b01:   used_next = used_q - ONE;
            default: used_next = used_q;
        endcase

        ram_cnt_next = ram_cnt;
        case ({wr_acc, ram_rd})
            2'b10:   ram_cnt_next = ram_cnt + ONE;
            2'b01:   ram_cnt_next = ram_cnt - ONE;
            default: ram_cnt_next = ram_cnt;
        endcase
    end

    // Storage array carries no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc && !flush)
            mem[wr_ptr] <= wr_frame;
        if (ram_rd)
            ram_q <= mem[rd_ptr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            used_q    <= '0;
            q_valid   <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
            last_q    <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_cnt   <= '0;
            used_q    <= '0;
            q_valid   <= 1'b0;
            out_valid <= 1'b0;
            out_q     <= '0;
            last_q    <= '0;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (ram_rd)
                rd_ptr <= rd_ptr + 1'b1;
            ram_cnt <= ram_cnt_next;
            used_q  <= used_next;
            full_q  <= (used_next == DEPTH);
            afull_q <= (used_next >= AF_THR);

            if (ram_rd)
                q_valid <= 1'b1;
            else if (q_move)
                q_valid <= 1'b0;

            if (rd_acc)
                last_q <= out_q;
            if (q_move) begin
                out_q     <= ram_q;
                out_valid <= 1'b1;
            end else if (rd_acc) begin
                out_valid <= 1'b0;
            end

            if (wr_req && full_q)
                ovf_q <= 1'b1;
            if (rd_req && !out_valid)
                unf_q <= 1'b1;
        end
    end

    assign rd_data = out_valid ? out_q : ((HOLD_LAST != 0) ? last_q : '0);
    assign empty   = !out_valid;
    assign full    = full_q;
    assign afull   = afull_q;
    assign used    = used_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

endmodule

// File: tb/tb_msu_sample_fifo.sv
// tb/tb_msu_sample_fifo.sv - directed self-checking bench for msu_sample_fifo
// Two instances share stimulus; the second differs only in holding the last popped frame.
module tb_msu_sample_fifo;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_req = 1'b0;
    logic        wr_mono = 1'b0;
    logic [31:0] wr_data = '0;
    logic        rd_req = 1'b0;

    logic        full0, afull0, empty0, ovf0, unf0;
    logic [31:0] rd_data0;
    logic [10:0] used0;
    logic        full1, afull1, empty1, ovf1, unf1;
    logic [31:0] rd_data1;
    logic [10:0] used1;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    msu_sample_fifo #(.DW(16), .CH(2), .AW(10), .AF_LEVEL(768), .HOLD_LAST(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wr_req), .wr_mono(wr_mono),
        .wr_data(wr_data), .full(full0), .afull(afull0), .rd_req(rd_req), .rd_data(rd_data0),
        .empty(empty0), .used(used0), .ovf(ovf0), .unf(unf0));

    msu_sample_fifo #(.DW(16), .CH(2), .AW(10), .AF_LEVEL(768), .HOLD_LAST(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_req(wr_req), .wr_mono(wr_mono),
        .wr_data(wr_data), .full(full1), .afull(afull1), .rd_req(rd_req), .rd_data(rd_data1),
        .empty(empty1), .used(used1), .ovf(ovf1), .unf(unf1));

    function automatic logic [31:0] frame(input int j);
        logic [15:0] lo;
        lo = 16'(j) ^ 16'h5A5A;
        return {16'(j), lo};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; wr_mono = 1'b0; wr_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if (used0 !== 11'd0) begin tests_failed++; $display("FAIL reset_used: got %0d want 0", used0); end
        tests_run++;
        if ({empty0, full0, afull0, ovf0, unf0} !== 5'b10000) begin
            tests_failed++; $display("FAIL reset_flags: got %b want 10000", {empty0, full0, afull0, ovf0, unf0});
        end
        tests_run++;
        if (rd_data0 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_data0: got %h want 0", rd_data0); end
        tests_run++;
        if (rd_data1 !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_data1: got %h want 0", rd_data1); end
    endtask

    task automatic test_first_write();
        do_reset();
        wr_data = 32'h1111_2222; wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        tests_run++;
        if (used0 !== 11'd1 || empty0 !== 1'b1) begin
            tests_failed++; $display("FAIL t1_edge_k: got used=%0d empty=%b want used=1 empty=1", used0, empty0);
        end
        tick();
        tests_run++;
        if (empty0 !== 1'b1) begin tests_failed++; $display("FAIL t1_edge_k1: got empty=%b want 1", empty0); end
        tick();
        tests_run++;
        if (empty0 !== 1'b0 || rd_data0 !== 32'h1111_2222 || used0 !== 11'd1) begin
            tests_failed++;
            $display("FAIL t1_edge_k2: got empty=%b data=%h used=%0d want 0 11112222 1", empty0, rd_data0, used0);
        end
    endtask

    task automatic test_fill_drain();
        int err;
        do_reset();
        err = 0;
        wr_req = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            wr_data = frame(i);
            tick();
            if (afull0 !== (i + 1 >= 768) || full0 !== (i + 1 == 1024) || used0 !== 11'(i + 1)) err++;
        end
        tests_run++;
        if (err != 0) begin tests_failed++; $display("FAIL t2_fill_track: got %0d mismatches want 0", err); end
        tests_run++;
        if (full0 !== 1'b1 || used0 !== 11'd1024 || ovf0 !== 1'b0) begin
            tests_failed++; $display("FAIL t2_full: got full=%b used=%0d ovf=%b want 1 1024 0", full0, used0, ovf0);
        end
        wr_data = 32'hBAD0_BAD0;
        tick();
        tests_run++;
        if (ovf0 !== 1'b1 || used0 !== 11'd1024) begin
            tests_failed++; $display("FAIL t2_ovf: got ovf=%b used=%0d want 1 1024", ovf0, used0);
        end
        rd_req = 1'b1;
        tests_run++;
        if (rd_data0 !== frame(0)) begin tests_failed++; $display("FAIL t2_head: got %h want %h", rd_data0, frame(0)); end
        tick();
        wr_req = 1'b0;
        tests_run++;
        if (used0 !== 11'd1023 || full0 !== 1'b0) begin
            tests_failed++; $display("FAIL t2_full_both: got used=%0d full=%b want 1023 0", used0, full0);
        end
        err = 0;
        for (int j = 1; j < 1024; j++) begin
            if (empty0 !== 1'b0 || rd_data0 !== frame(j)) err++;
            tick();
        end
        rd_req = 1'b0;
        tests_run++;
        if (err != 0) begin tests_failed++; $display("FAIL t2_drain_order: got %0d mismatches want 0", err); end
        tests_run++;
        if (empty0 !== 1'b1 || used0 !== 11'd0 || unf0 !== 1'b0 || afull0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_drained: got empty=%b used=%0d unf=%b afull=%b want 1 0 0 0", empty0, used0, unf0, afull0);
        end
    endtask

    task automatic test_mono();
        do_reset();
        wr_mono = 1'b1; wr_data = 32'hDEAD_BEEF; wr_req = 1'b1;
        tick();
        wr_req = 1'b0; wr_mono = 1'b0;
        tick(); tick();
        tests_run++;
        if (rd_data0 !== 32'hBEEF_BEEF || empty0 !== 1'b0) begin
            tests_failed++; $display("FAIL t3_mono: got %h empty=%b want beefbeef 0", rd_data0, empty0);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tests_run++;
        if (empty0 !== 1'b1 || used0 !== 11'd0) begin
            tests_failed++; $display("FAIL t3_pop: got empty=%b used=%0d want 1 0", empty0, used0);
        end
    endtask

    task automatic test_back_to_back();
        int err_data, err_used;
        do_reset();
        wr_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wr_data = frame(i);
            tick();
        end
        wr_req = 1'b0;
        tick(); tick();
        tests_run++;
        if (used0 !== 11'd5 || rd_data0 !== frame(0)) begin
            tests_failed++; $display("FAIL t4_setup: got used=%0d data=%h want 5 %h", used0, rd_data0, frame(0));
        end
        err_data = 0; err_used = 0;
        wr_req = 1'b1; rd_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            wr_data = frame(c + 5);
            if (empty0 !== 1'b0 || rd_data0 !== frame(c)) err_data++;
            tick();
            if (used0 !== 11'd5) err_used++;
        end
        wr_req = 1'b0; rd_req = 1'b0;
        tests_run++;
        if (err_data != 0) begin tests_failed++; $display("FAIL t4_stream_data: got %0d mismatches want 0", err_data); end
        tests_run++;
        if (err_used != 0) begin tests_failed++; $display("FAIL t4_stream_used: got %0d mismatches want 0", err_used); end
        tests_run++;
        if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin
            tests_failed++; $display("FAIL t4_flags: got ovf=%b unf=%b want 0 0", ovf0, unf0);
        end
    endtask

    task automatic test_underflow_hold();
        do_reset();
        wr_req = 1'b1;
        wr_data = 32'h1234_5678; tick();
        wr_data = 32'h9ABC_DEF0; tick();
        wr_req = 1'b0;
        tick(); tick();
        rd_req = 1'b1;
        tests_run++;
        if (rd_data0 !== 32'h1234_5678) begin tests_failed++; $display("FAIL t5_pop_a: got %h want 12345678", rd_data0); end
        tick();
        tests_run++;
        if (rd_data0 !== 32'h9ABC_DEF0 || empty0 !== 1'b0) begin
            tests_failed++; $display("FAIL t5_pop_b: got %h empty=%b want 9abcdef0 0", rd_data0, empty0);
        end
        tick();
        rd_req = 1'b0;
        tests_run++;
        if (empty0 !== 1'b1 || rd_data0 !== 32'h0 || unf0 !== 1'b0) begin
            tests_failed++; $display("FAIL t5_empty0: got empty=%b data=%h unf=%b want 1 0 0", empty0, rd_data0, unf0);
        end
        tests_run++;
        if (empty1 !== 1'b1 || rd_data1 !== 32'h9ABC_DEF0) begin
            tests_failed++; $display("FAIL t5_hold_last: got empty=%b data=%h want 1 9abcdef0", empty1, rd_data1);
        end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tests_run++;
        if (unf0 !== 1'b1 || unf1 !== 1'b1 || used0 !== 11'd0) begin
            tests_failed++; $display("FAIL t5_unf: got unf0=%b unf1=%b used=%0d want 1 1 0", unf0, unf1, used0);
        end
        tests_run++;
        if (rd_data1 !== 32'h9ABC_DEF0 || rd_data0 !== 32'h0) begin
            tests_failed++; $display("FAIL t5_after_unf: got d0=%h d1=%h want 0 9abcdef0", rd_data0, rd_data1);
        end
    endtask

    task automatic test_flush_reset();
        do_reset();
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        wr_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wr_data = frame(i + 7);
            tick();
        end
        tests_run++;
        if (used0 !== 11'd300 || unf0 !== 1'b1 || afull0 !== 1'b0) begin
            tests_failed++; $display("FAIL t6_prefill: got used=%0d unf=%b afull=%b want 300 1 0", used0, unf0, afull0);
        end
        flush = 1'b1; rd_req = 1'b1; wr_data = 32'hCAFE_F00D;
        tick();
        flush = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        tests_run++;
        if (used0 !== 11'd0 || empty0 !== 1'b1 || ovf0 !== 1'b0 || unf0 !== 1'b0 || full0 !== 1'b0) begin
            tests_failed++;
            $display("FAIL t6_flush: got used=%0d empty=%b ovf=%b unf=%b full=%b want 0 1 0 0 0", used0, empty0, ovf0, unf0, full0);
        end
        tests_run++;
        if (rd_data1 !== 32'h0 || rd_data0 !== 32'h0) begin
            tests_failed++; $display("FAIL t6_flush_data: got d0=%h d1=%h want 0 0", rd_data0, rd_data1);
        end
        tick(); tick(); tick();
        tests_run++;
        if (empty0 !== 1'b1 || used0 !== 11'd0) begin
            tests_failed++; $display("FAIL t6_no_write: got empty=%b used=%0d want 1 0", empty0, used0);
        end
        wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = frame(i + 40);
            tick();
        end
        tests_run++;
        if (empty0 !== 1'b0 || rd_data0 !== frame(40) || used0 !== 11'd4) begin
            tests_failed++; $display("FAIL t6_burst: got empty=%b data=%h used=%0d want 0 %h 4", empty0, rd_data0, used0, frame(40));
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (used0 !== 11'd0 || {empty0, full0, afull0, ovf0, unf0} !== 5'b10000 || rd_data0 !== 32'h0 || rd_data1 !== 32'h0) begin
            tests_failed++;
            $display("FAIL t6_async_reset: got used=%0d flags=%b d0=%h d1=%h want 0 10000 0 0",
                     used0, {empty0, full0, afull0, ovf0, unf0}, rd_data0, rd_data1);
        end
        wr_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_fill_drain();
        test_mono();
        test_back_to_back();
        test_underflow_hold();
        test_flush_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
